// File: rtl/dot3_share_arbiter.sv
// Round-robin sequencer sharing one 3-element FP dot-product unit among NREQ requesters.
// Optional RUN-state timeout is built only when DOT3_TIMEOUT_EN is defined.
module dot3_share_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned RST_HOLD = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                CLK2,
  input  logic                RST,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*96-1:0]  req_a,
  input  logic [NREQ*96-1:0]  req_b,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     res_valid,
  output logic [31:0]         res,
  output logic                err,
  output logic                busy,
  output logic [31:0]         dot_a1,
  output logic [31:0]         dot_a2,
  output logic [31:0]         dot_a3,
  output logic [31:0]         dot_b1,
  output logic [31:0]         dot_b2,
  output logic [31:0]         dot_b3,
  output logic                dot_rst,
  input  logic                dot_rdy,
  input  logic [31:0]         dot_res
);

  localparam int unsigned IW        = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W    = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_IX = IW'(NREQ - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(RST_HOLD - 1);

  if (NREQ < 2 || NREQ > 8 || RST_HOLD < 1 || RST_HOLD > 15 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("dot3_share_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur;
  logic [3:0]    hold;

  logic [95:0] a_slice [NREQ];
  logic [95:0] b_slice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_slice[g] = req_a[g*96 +: 96];
    assign b_slice[g] = req_b[g*96 +: 96];
  end

  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic [IW:0]   sum;

  // Scan circularly starting at ptr; first hit wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum  = {1'b0, ptr} + (IW+1)'(k);
      cand = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef DOT3_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tcnt;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK2 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      hold      <= '0;
      grant     <= '0;
      res_valid <= '0;
      res       <= '0;
      dot_rst   <= 1'b1;
      dot_a1    <= '0;
      dot_a2    <= '0;
      dot_a3    <= '0;
      dot_b1    <= '0;
      dot_b2    <= '0;
      dot_b3    <= '0;
`ifdef DOT3_TIMEOUT_EN
      tcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          dot_rst   <= 1'b1;
          res_valid <= '0;
          if (found) begin
            dot_a1 <= a_slice[sel][31:0];
            dot_a2 <= a_slice[sel][63:32];
            dot_a3 <= a_slice[sel][95:64];
            dot_b1 <= b_slice[sel][31:0];
            dot_b2 <= b_slice[sel][63:32];
            dot_b3 <= b_slice[sel][95:64];
            grant  <= NREQ'(1) << sel;
            cur    <= sel;
            hold   <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (hold == HOLD_LAST) begin
            dot_rst <= 1'b0;
            state   <= RUN;
`ifdef DOT3_TIMEOUT_EN
            tcnt    <= '0;
`endif
          end else begin
            hold <= hold + 4'd1;
          end
        end
        RUN: begin
          if (dot_rdy) begin
            res       <= dot_res;
            res_valid <= grant;
            dot_rst   <= 1'b1;
            state     <= DONE;
`ifdef DOT3_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (tcnt == TO_LAST) begin
            res       <= 32'h7FC0_0000;
            err_q     <= 1'b1;
            res_valid <= grant;
            dot_rst   <= 1'b1;
            state     <= DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
`endif
          end
        end
        DONE: begin
          res_valid <= '0;
          grant     <= '0;
          ptr       <= (cur == LAST_IX) ? '0 : cur + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dot3_share_arbiter.md
Name: dot3_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 3-element floating-point dot-product unit among NREQ requesters in the sphere-box collision datapath.
- Captures the winning requester's operands and drives them to the shared unit.
- Controls the unit's reset-as-start input, waits for its ready flag, and returns the 32-bit IEEE-754 result to the winning requester with a one-cycle valid pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- RST_HOLD, 2, cycles the dot unit's reset is held high before each operation (1..15).
- TIMEOUT, 255, RUN-state cycle limit; used only with the optional feature (1..65535).

Ports:
- CLK2 input 1: clock.
- RST input 1: reset, asynchronous, active-high.
- req input NREQ: per-requester request level.
- req_a input NREQ*96: per-requester a vector; slice i = {a3,a2,a1}, 32 bits each.
- req_b input NREQ*96: per-requester b vector; slice i = {b3,b2,b1}, 32 bits each.
- grant output NREQ: one-hot; high from selection until the DONE state.
- res_valid output NREQ: one-hot one-cycle pulse marking which requester owns res.
- res output 32: last result, held until the next completion.
- err output 1: high together with res_valid when the result is a timeout result.
- busy output 1: high whenever the state is not IDLE.
- dot_a1, dot_a2, dot_a3, dot_b1, dot_b2, dot_b3 output 32 each: registered operands to the dot unit.
- dot_rst output 1: dot unit reset. High = held idle; falling edge starts a computation.
- dot_rdy input 1: dot unit result ready (level, synchronous to CLK2).
- dot_res input 32: dot unit result.

Behaviour:
- Reset values:
  - grant=0, res_valid=0, res=0, err=0, busy=0.
  - dot_rst=1, all dot operands=0.
  - Round-robin pointer ptr=0, hold counter=0, state=IDLE.
  - Reset takes effect immediately, including mid-operation. It aborts any operation with no res_valid pulse, and dot_rst goes high asynchronously.
- IDLE:
  - dot_rst=1, res_valid=0.
  - If req is nonzero, select the lowest index i >= ptr with req[i]=1. If none exists, wrap to the lowest set index below ptr.
  - On selection, in the same clock edge: register slice i of req_a/req_b onto the dot operands, set grant[i]=1, clear the hold counter, go to LOAD.
- LOAD:
  - dot_rst stays 1 and the counter increments each cycle.
  - When the counter reaches RST_HOLD-1: dot_rst<=0, go to RUN.
- RUN:
  - dot_rst=0; operands stay frozen even if req_a/req_b change.
  - When dot_rdy=1 is sampled:
    - res<=dot_res, err<=0, res_valid[i]<=1 for one cycle.
    - dot_rst<=1, go to DONE.
- DONE, one cycle:
  - res_valid<=0, grant<=0.
  - ptr<=(i+1) mod NREQ.
  - Go to IDLE.
- Latency:
  - A request sampled in IDLE at edge 0 gives grant at edge 0 and dot_rst falling at edge RST_HOLD.
  - res_valid follows at edge RST_HOLD + L + 1, where L is the unit's cycles from start to dot_rdy.
  - Minimum back-to-back spacing between operations is RST_HOLD + L + 3 cycles.
- Handshake rules:
  - A requester holds req high until it sees its res_valid pulse, then drops req.
  - If req is still high in IDLE after DONE, it counts as a new request. It competes behind the requesters after it because ptr has advanced.
  - Dropping req while granted does not abort. The operation completes and res_valid still pulses.
- Boundary conditions:
  - dot_rdy high in IDLE, LOAD or DONE: ignored (stale flag from the previous run).
  - All NREQ requesting at once: served in order ptr, ptr+1, ... with wrap; no requester waits more than NREQ-1 operations.
  - ptr = NREQ-1 wraps to 0.
  - A requester whose grant is high and that re-asserts req during RUN: no effect.

Optional Feature:
- Macro: DOT3_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT with no dot_rdy: res<=32'h7FC00000 (quiet NaN), err<=1, res_valid[i] pulses, dot_rst<=1, go to DONE.
  - err clears on the next normal completion or on reset.
  - dot_rdy in the same cycle that the counter reaches TIMEOUT: the normal result wins.
- Without the macro: RUN waits indefinitely, err is tied 0, and no counter is built.

Test Plan:
- Single request: req=4'b0001, a=(3F800000,40000000,40400000) i.e. (1,2,3), b=(40800000,40A00000,40C00000) i.e. (4,5,6), bench dot unit model with L=5 -> grant=0001 at edge 0, dot_rst falls at edge 2, res_valid=0001 at edge 8 with res=42000000 (32.0), err=0.
- Simultaneous req=4'b1111 held high after reset -> grants in order 0001, 0010, 0100, 1000, then 0001 again; each res_valid matches its grant; grant is zero for 1 cycle between operations.
- Fairness after wrap: ptr=2 (after serving requester 1), req=4'b0011 -> requester 0 granted; req=4'b1001 with ptr=1 -> requester 3 granted.
- Operand freeze: change req_a slice 0 to all-zero during RUN -> res is still 42000000; dot_rdy forced high in IDLE -> no res_valid.
- RST pulsed during RUN -> grant=0, busy=0 and dot_rst=1 immediately, no res_valid; a new request afterwards gives grant=0001 (ptr=0).
- With DOT3_TIMEOUT_EN, TIMEOUT=10, dot unit model never ready -> res_valid pulses 10 cycles after dot_rst falls, res=7FC00000, err=1; the next normal operation returns err=0.
